// File: rtl/mem_access_unit.sv
// Data-memory access unit: one load/store per handshake, byte loads extracted and extended,
// byte stores done as read-modify-write on a word-wide memory with combinational read.
module mem_access_unit #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   output logic [1:0]        mem_byte_ext,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_SW  = 3'd3;
   localparam logic [2:0] OP_SB  = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      SB_RD  = 3'd2,
      SB_WR  = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [2:0]        op_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0;
   logic [31:0]       rdata_p1;
   logic              err_p1;
   logic [31:0]       merged_p1;
   logic              bad_req;
   logic              accept;

   // Big-endian lane select: offset 0 is the most significant byte.
   function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] off);
      logic [7:0] b;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   function automatic logic signed [31:0] byte_ext(input logic [7:0] b, input logic sext);
      logic signed [7:0]  sb;
      logic signed [31:0] r;
      sb = signed'(b);
      if (sext)
         r = 32'(sb);
      else
         r = signed'({24'd0, b});
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [7:0] b,
                                              input logic [1:0] off);
      logic [31:0] r;
      r = w;
      case (off)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

   assign accept  = req_valid && (state == IDLE);
   assign bad_req = (req_op > OP_SB) ||
                    (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (bad_req)
                  state_nx = RESP;
               else if (req_op == OP_SB)
                  state_nx = SB_RD;
               else
                  state_nx = ACCESS;
            end
         end
         ACCESS:  state_nx = RESP;
         SB_RD:   state_nx = SB_WR;
         SB_WR:   state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Stage p0: request capture; stage p1: load result / merged store word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_p0     <= '0;
         addr_p0   <= '0;
         wdata_p0  <= '0;
         rdata_p1  <= '0;
         err_p1    <= 1'b0;
         merged_p1 <= '0;
      end else begin
         if (accept) begin
            op_p0    <= req_op;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            rdata_p1 <= '0;
            err_p1   <= bad_req;
         end
         if (state == ACCESS) begin
            case (op_p0)
               OP_LW:   rdata_p1 <= mem_rdata;
               OP_LB:   rdata_p1 <= byte_ext(lane_sel(mem_rdata, addr_p0[1:0]), 1'b1);
               OP_LBU:  rdata_p1 <= byte_ext(lane_sel(mem_rdata, addr_p0[1:0]), 1'b0);
               default: rdata_p1 <= rdata_p1;
            endcase
         end
         if (state == SB_RD)
            merged_p1 <= lane_merge(mem_rdata, wdata_p0[7:0], addr_p0[1:0]);
      end
   end

   // Memory port is decoded from registered state only.
   assign mem_addr     = {addr_p0[ADDR_W-1:2], 2'b00};
   assign mem_we       = (state == SB_WR) || ((state == ACCESS) && (op_p0 == OP_SW));
   assign mem_wd       = (state == SB_WR) ? merged_p1 :
                         (mem_we ? wdata_p0 : 32'd0);
   assign mem_byte_ext = 2'b11;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdata_p1;
   assign resp_err   = err_p1;

endmodule
